alu_pipe_ccr: RTL
=================

// Module: alu_pipe_ccr
// PURPOSE
//  Next-generation datapath ALU: WIDTH-parametrised, registered result, persistent
//  condition-code register (CCR: Z,N,C,V). Valid/ready handshake toward the execute stage.
//  Carry chains (ADC, RLC, RRC) use the stored carry. Optional iterative multiplier.
//  Sits in EX stage; result/CCR feed the EX/MEM register and branch unit.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 4
// PORTS
//  CLK        in   1      clock, rising edge
//  RST_N      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      high when idle; accept = in_valid & in_ready
//  opcode     in   4      operation select
//  func       in   2      sub-operation for opcodes 6 and 8
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  flush      in   1      synchronous abort of any in-flight operation
//  ccr_wr     in   1      load CCR from ccr_in (context restore)
//  ccr_in     in   4      {Z,N,C,V} restore value
//  out_valid  out  1      one-cycle pulse; result and CCR are final
//  result     out  WIDTH  registered result
//  result_hi  out  WIDTH  MUL upper half; 0 for all other ops
//  ccr        out  4      registered {Z,N,C,V}
// BEHAVIOUR
//  Reset: result, result_hi, ccr = 0; out_valid = 0; state = IDLE; in_ready = 1.
//  States: IDLE, MUL_RUN. in_ready = (state==IDLE), combinational from state.
//  Single-cycle ops: result/CCR written at the accept edge; out_valid high the next cycle.
//  Back-to-back accepts legal. Each op reads CCR as committed by the prior op.
//  Flag rule: flags not listed for an op hold their value.
//  0 NOP: result=0; no flag change.     1 MOV: result=B; Z,N.
//  2 ADD: {C,r}=A+B; V=signed ovf; Z,N.
//  3 SUB: r=A-B; C=borrow (A<B unsigned); V=signed ovf; Z,N.
//  4 AND, 5 OR: Z,N.
//  6 func 00 RLC: r={B[W-2:0],C}; C<=B[W-1]; Z,N.  func 01 RRC: r={C,B[W-1:1]}; C<=B[0]; Z,N.
//    func 10 SETC: C=1.  func 11 CLRC: C=0. For both, r=0 and Z,N unchanged.
//  7 ADC: {C,r}=A+B+C; V,Z,N.
//  8 func 00 NOT ~B; 01 NEG -B (Z,N only); 10 INC B+1, 11 DEC B-1 (C,V,Z,N; DEC C = borrow).
//  9 MUL: see CONFIGURATION.   10-15: illegal; result=0; CCR unchanged; out_valid still pulses.
//  Z = (r==0) and N = r[W-1] whenever updated.
//  ccr_wr at the same edge as a flag update: ccr_in wins; result is unaffected.
//  flush: state->IDLE; a pending MUL is discarded with no out_valid. A flush-edge accept is dropped.
//  result and CCR hold their last values.
//  Reset at any time, incl. mid-MUL: immediate return to reset values.
// CONFIGURATION
//  ALU_MUL_EN defined: opcode 9 = unsigned shift-add multiply, {result_hi,result}=A*B.
//    Accept edge loads operands and enters MUL_RUN with counter=WIDTH.
//    One iteration per cycle; in_ready=0 throughout.
//    The result, result_hi and CCR write lands WIDTH edges after the accept edge; out_valid pulses next cycle.
//    Flags: C=(result_hi!=0); Z,N from result; V unchanged.
//  ALU_MUL_EN undefined: no MUL_RUN state or datapath; opcode 9 behaves as illegal.
// TESTING (WIDTH=8)
//  ADD A=7F B=01 -> next cycle out_valid=1, result=80, ccr Z0 N1 C0 V1.
//  SETC, then RLC B=80 -> result=01, C=1, Z=0, N=0; then RRC B=01 -> result=80, C=1.
//  SUB 00-01 -> FF, C1 N1; then ADC A=01 B=01 -> 03, C0.
//  MUL 0F*11 (macro on) -> in_ready low 8 cycles, result=FF, hi=00, C0. Macro off -> result 00, CCR unchanged.
//  Start MUL, then RST_N=0 on cycle 3 -> all outputs 0, in_ready=1, no out_valid.
//    Same with flush -> no out_valid, CCR held.
//  ADD 80+80 with ccr_wr=1, ccr_in=4'b0000 same edge -> ccr=0000, result=00.

Source files
------------

// File: rtl/alu_pipe_ccr.sv
// EX-stage ALU with registered result and a persistent {Z,N,C,V} condition-code register.
// Define ALU_MUL_EN to add the iterative shift-add multiplier on opcode 9 (MUL_RUN state).
module alu_pipe_ccr #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [1:0]       func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             ccr_wr,
    input  logic [3:0]       ccr_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       ccr
);

    // Handshake: an op is taken on a rising edge where in_valid & in_ready & !flush;
    // out_valid is a one-cycle pulse, with no back-pressure, when result/ccr are final.
`ifdef ALU_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

    state_t state, next_state;
    logic   accept;
    logic   is_mul;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;
`ifdef ALU_MUL_EN
    assign is_mul   = (opcode == 4'd9);
`else
    assign is_mul   = 1'b0;
`endif

    // Single-cycle datapath
    logic [WIDTH:0]   add_sum, adc_sum, sub_diff, inc_sum, dec_diff;
    logic [WIDTH-1:0] alu_r;
    logic             f_z, f_n, f_c, f_v, upd_zn;

    assign add_sum  = {1'b0, A} + {1'b0, B};
    assign adc_sum  = add_sum + {{WIDTH{1'b0}}, ccr[1]};
    assign sub_diff = {1'b0, A} - {1'b0, B};
    assign inc_sum  = {1'b0, B} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, B} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_r  = '0;
        f_z    = ccr[3];
        f_n    = ccr[2];
        f_c    = ccr[1];
        f_v    = ccr[0];
        upd_zn = 1'b0;
        case (opcode)
            4'd1: begin
                alu_r  = B;
                upd_zn = 1'b1;
            end
            4'd2: begin
                alu_r  = add_sum[WIDTH-1:0];
                f_c    = add_sum[WIDTH];
                f_v    = (A[WIDTH-1] == B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
                upd_zn = 1'b1;
            end
            4'd3: begin
                alu_r  = sub_diff[WIDTH-1:0];
                f_c    = sub_diff[WIDTH];
                f_v    = (A[WIDTH-1] != B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
                upd_zn = 1'b1;
            end
            4'd4: begin
                alu_r  = A & B;
                upd_zn = 1'b1;
            end
            4'd5: begin
                alu_r  = A | B;
                upd_zn = 1'b1;
            end
            4'd6: begin
                case (func)
                    2'b00: begin
                        alu_r  = {B[WIDTH-2:0], ccr[1]};
                        f_c    = B[WIDTH-1];
                        upd_zn = 1'b1;
                    end
                    2'b01: begin
                        alu_r  = {ccr[1], B[WIDTH-1:1]};
                        f_c    = B[0];
                        upd_zn = 1'b1;
                    end
                    2'b10:   f_c = 1'b1;
                    default: f_c = 1'b0;
                endcase
            end
            4'd7: begin
                alu_r  = adc_sum[WIDTH-1:0];
                f_c    = adc_sum[WIDTH];
                f_v    = (A[WIDTH-1] == B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
                upd_zn = 1'b1;
            end
            4'd8: begin
                upd_zn = 1'b1;
                case (func)
                    2'b00: alu_r = ~B;
                    2'b01: alu_r = -B;
                    2'b10: begin
                        alu_r = inc_sum[WIDTH-1:0];
                        f_c   = inc_sum[WIDTH];
                        f_v   = ~B[WIDTH-1] & alu_r[WIDTH-1];
                    end
                    default: begin
                        alu_r = dec_diff[WIDTH-1:0];
                        f_c   = dec_diff[WIDTH];
                        f_v   = B[WIDTH-1] & ~alu_r[WIDTH-1];
                    end
                endcase
            end
            default: alu_r = '0;
        endcase
        if (upd_zn) begin
            f_z = (alu_r == '0);
            f_n = alu_r[WIDTH-1];
        end
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mul_a, mul_hi, mul_lo, step_hi, step_lo;
    logic [WIDTH:0]   mul_sum;
    logic [CW-1:0]    mul_cnt;

    // One shift-add step: conditionally add A into the high half, then shift {carry,hi,lo} right.
    assign mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
    assign step_hi = mul_sum[WIDTH:1];
    assign step_lo = {mul_sum[0], mul_lo[WIDTH-1:1]};
`endif

    always_comb begin
        next_state = state;
`ifdef ALU_MUL_EN
        case (state)
            IDLE:    if (accept && is_mul) next_state = MUL_RUN;
            MUL_RUN: if (mul_cnt == CW'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
`endif
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result    <= '0;
            result_hi <= '0;
            ccr       <= '0;
            out_valid <= 1'b0;
`ifdef ALU_MUL_EN
            mul_a     <= '0;
            mul_hi    <= '0;
            mul_lo    <= '0;
            mul_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_mul) begin
                result    <= alu_r;
                result_hi <= '0;
                ccr       <= {f_z, f_n, f_c, f_v};
                out_valid <= 1'b1;
            end
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                mul_a   <= A;
                mul_hi  <= '0;
                mul_lo  <= B;
                mul_cnt <= CW'(WIDTH);
            end
            if (state == MUL_RUN && !flush) begin
                mul_hi  <= step_hi;
                mul_lo  <= step_lo;
                mul_cnt <= mul_cnt - CW'(1);
                if (mul_cnt == CW'(1)) begin
                    result    <= step_lo;
                    result_hi <= step_hi;
                    ccr       <= {(step_lo == '0), step_lo[WIDTH-1], (step_hi != '0), ccr[0]};
                    out_valid <= 1'b1;
                end
            end
`endif
            // Context restore overrides any flag update landing on the same edge.
            if (ccr_wr) ccr <= ccr_in;
        end
    end

endmodule
